// File: rtl/adc_pkg.sv
// Shared types and constants for the dual-channel SPI ADC front end.
// Frame layout and the command-bit encoding live here.
package adc_pkg;

  typedef enum logic [1:0] {
    GAP,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int FRAME_BITS = 17;
  localparam int NULL_BIT   = 5;
  localparam int DATA_W     = 12;

  localparam logic START = 1'b1;
  localparam logic SGL   = 1'b1;
  localparam logic MSBF  = 1'b1;

  // Command bit driven during SCK period k (1-based).
  function automatic logic cmd_bit(
    input logic [4:0] k,
    input logic       ch
  );
    logic b;
    b = 1'b0;
    unique case (k)
      5'd1:    b = START;
      5'd2:    b = SGL;
      5'd3:    b = ch;
      5'd4:    b = MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_xfer.sv
// One SPI frame: setup, 17 SCK periods, hold.
// Owns the SCK divider, bit counter and result shifter.
module adc_spi_xfer
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              channel,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ch_q, ch_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              div_end;

  assign div_end = (div_q == DIV_END);

  // Next-state and next-pin values for the frame sequencer.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ch_d    = ch_q;
    sh_d    = sh_q;
    unique case (state_q)
      GAP: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = 5'd1;
          ch_d    = channel;
          mosi_d  = cmd_bit(5'd1, channel);
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (sck_q && div_q == '0
            && bit_q > 5'(NULL_BIT)) begin
          sh_d = {sh_q[DATA_W-2:0], miso};
        end
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sck_q) begin
            sck_d  = 1'b0;
            mosi_d = cmd_bit(bit_q + 5'd1, ch_q);
          end else if (bit_q == 5'(FRAME_BITS)) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 5'd1;
            sck_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = GAP;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  // Sequencer registers; reset raises cs_n at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GAP;
      div_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ch_q    <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ch_q    <= ch_d;
      sh_q    <= sh_d;
    end
  end

  assign busy   = (state_q != GAP);
  assign done   = (state_q == HOLD) && div_end;
  assign result = sh_q;
  assign cs_n   = cs_q;
  assign sck    = sck_q;
  assign mosi   = mosi_q;

endmodule

// File: rtl/adc_sampler.sv
// Alternating two-channel ADC sampler with box averaging.
// Publishes both averages together with a one-cycle valid.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 24,
  parameter int SAMPLE_GAP = 1000,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miso,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi,
  output logic [DATA_W-1:0] p1data,
  output logic [DATA_W-1:0] p2data,
  output logic              valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int GW    = $clog2(SAMPLE_GAP + 1);
  localparam int SW    = AVG_LOG2 + 1;
  localparam logic [GW-1:0] GAP_END = GW'(SAMPLE_GAP - 1);
  localparam logic [SW-1:0] SMAX    = SW'((1 << AVG_LOG2) - 1);

  logic              busy;
  logic              done;
  logic              start;
  logic [DATA_W-1:0] result;
  logic [GW-1:0]     gap_q;
  logic              chan;
  logic [SW-1:0]     smp;
  logic [ACC_W-1:0]  acc0, acc1;
  logic [ACC_W-1:0]  sum0, sum1;

  assign start = !busy && (gap_q == GAP_END);

  adc_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .channel (chan),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cs_n    (cs_n),
    .sck     (sck),
    .mosi    (mosi)
  );

  // Running sums including the conversion just finished.
  always_comb begin
    sum0 = acc0 + ACC_W'(result);
    sum1 = acc1 + ACC_W'(result);
  end

  // Idle timer between frames; zero while a frame runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else if (busy || start) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 1'b1;
    end
  end

  // Channel toggle, accumulation and output publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan   <= 1'b0;
      smp    <= '0;
      acc0   <= '0;
      acc1   <= '0;
      p1data <= '0;
      p2data <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (done) begin
        chan <= ~chan;
        if (!chan) begin
          acc0 <= sum0;
        end else if (smp == SMAX) begin
          p1data <= DATA_W'(acc0 >> AVG_LOG2);
          p2data <= DATA_W'(sum1 >> AVG_LOG2);
          acc0   <= '0;
          acc1   <= '0;
          smp    <= '0;
          valid  <= 1'b1;
        end else begin
          acc1 <= sum1;
          smp  <= smp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: two instances (no averaging, 4x averaging)
// driven by a behavioural MCP3202-style ADC model.
module tb_adc_sampler;

  typedef struct packed {
    logic [3:0][11:0] a;
    logic [3:0][11:0] b;
    logic [11:0]      e1;
    logic [11:0]      e2;
  } vec_t;

  logic        clk;
  logic        rst    [2];
  logic        miso   [2];
  logic        cs_n   [2];
  logic        sck    [2];
  logic        mosi   [2];
  logic        valid  [2];
  logic [11:0] p1     [2];
  logic [11:0] p2     [2];

  logic [11:0] s0 [2][16];
  logic [11:0] s1 [2][16];
  int          n0 [2];
  int          n1 [2];
  int          r0 [2];
  int          r1 [2];
  logic [11:0] d0 [2];
  logic [11:0] d1 [2];
  logic [11:0] word [2];

  logic        cprev [2];
  logic        sprev [2];
  logic        vprev [2];
  int          m_bit [2];
  logic        m_odd [2];
  logic [3:0]  cmd   [2];
  logic [3:0]  cmdlog [2][2];
  int          low_cnt [2];
  int          frames  [2];
  int          len_bad [2];
  int          idle_bad [2];
  int          vcnt [2];
  int          dbl  [2];

  int cyc;
  int pass;
  int total;

  vec_t t0 [3];
  vec_t t1 [4];

  adc_sampler #(
    .CLK_DIV    (2),
    .SAMPLE_GAP (4),
    .AVG_LOG2   (0)
  ) u0 (
    .clk    (clk),
    .reset  (rst[0]),
    .miso   (miso[0]),
    .cs_n   (cs_n[0]),
    .sck    (sck[0]),
    .mosi   (mosi[0]),
    .p1data (p1[0]),
    .p2data (p2[0]),
    .valid  (valid[0])
  );

  adc_sampler #(
    .CLK_DIV    (2),
    .SAMPLE_GAP (4),
    .AVG_LOG2   (2)
  ) u1 (
    .clk    (clk),
    .reset  (rst[1]),
    .miso   (miso[1]),
    .cs_n   (cs_n[1]),
    .sck    (sck[1]),
    .mosi   (mosi[1]),
    .p1data (p1[1]),
    .p2data (p2[1]),
    .valid  (valid[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ADC model, evaluated on falling clk edges.
  initial begin
    for (int g = 0; g < 2; g++) begin
      cprev[g] = 1'b1;
      sprev[g] = 1'b0;
      vprev[g] = 1'b0;
      m_bit[g] = 0;
      m_odd[g] = 1'b0;
      cmd[g] = 4'h0;
      cmdlog[g][0] = 4'h0;
      cmdlog[g][1] = 4'h0;
      word[g] = 12'h0;
      miso[g] = 1'b0;
      low_cnt[g] = 0;
      frames[g] = 0;
      len_bad[g] = 0;
      idle_bad[g] = 0;
      vcnt[g] = 0;
      dbl[g] = 0;
      r0[g] = 0;
      r1[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!cs_n[g] && cprev[g]) begin
          m_bit[g] = 0;
          low_cnt[g] = 0;
        end
        if (!cs_n[g]) low_cnt[g] = low_cnt[g] + 1;
        if (cs_n[g] && !cprev[g] && !rst[g]) begin
          frames[g] = frames[g] + 1;
          if (low_cnt[g] != 72) len_bad[g] = len_bad[g] + 1;
          if (frames[g] <= 2) cmdlog[g][frames[g]-1] = cmd[g];
        end
        if (!cs_n[g] && sck[g] && !sprev[g]) begin
          m_bit[g] = m_bit[g] + 1;
          if (m_bit[g] <= 4) cmd[g][4-m_bit[g]] = mosi[g];
          if (m_bit[g] == 3) begin
            m_odd[g] = mosi[g];
            if (mosi[g]) begin
              if (r1[g] < n1[g]) begin
                word[g] = s1[g][r1[g]];
                r1[g] = r1[g] + 1;
              end else begin
                word[g] = d1[g];
              end
            end else begin
              if (r0[g] < n0[g]) begin
                word[g] = s0[g][r0[g]];
                r0[g] = r0[g] + 1;
              end else begin
                word[g] = d0[g];
              end
            end
          end
        end
        if (!sck[g] && sprev[g]) begin
          if (m_bit[g] >= 5 && m_bit[g] <= 16)
            miso[g] = word[g][16-m_bit[g]];
          else
            miso[g] = 1'b0;
        end
        if (cs_n[g] && sck[g]) idle_bad[g] = idle_bad[g] + 1;
        if (valid[g]) begin
          vcnt[g] = vcnt[g] + 1;
          if (vprev[g]) dbl[g] = dbl[g] + 1;
        end
        cprev[g] = cs_n[g];
        sprev[g] = sck[g];
        vprev[g] = valid[g];
      end
    end
  end

  function automatic vec_t mk(
    input logic [11:0] a0, a1, a2, a3,
    input logic [11:0] b0, b1, b2, b3,
    input logic [11:0] e1, e2
  );
    vec_t v;
    v.a  = {a3, a2, a1, a0};
    v.b  = {b3, b2, b1, b0};
    v.e1 = e1;
    v.e2 = e2;
    return v;
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total = total + 1;
    if (act === exp) pass = pass + 1;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic wait_valid(
    input int    g,
    input int    budget,
    input string nm
  );
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid[g]) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  int  t_rel;
  int  k;
  bit  hit;

  initial begin
    pass  = 0;
    total = 0;
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    t0[0] = mk(12'hABC, 0, 0, 0, 12'h123, 0, 0, 0,
               12'hABC, 12'h123);
    t0[1] = mk(12'h000, 0, 0, 0, 12'hFFF, 0, 0, 0,
               12'h000, 12'hFFF);
    t0[2] = mk(12'h555, 0, 0, 0, 12'hAAA, 0, 0, 0,
               12'h555, 12'hAAA);
    t1[0] = mk(12'h100, 12'h102, 12'h104, 12'h106,
               12'h001, 12'h001, 12'h001, 12'h002,
               12'h103, 12'h001);
    t1[1] = mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
               12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
               12'hFFF, 12'hFFF);
    t1[2] = mk(12'h000, 12'h001, 12'h002, 12'h003,
               12'h010, 12'h020, 12'h030, 12'h041,
               12'h001, 12'h028);
    t1[3] = mk(12'h800, 12'h800, 12'h7FF, 12'h7FF,
               12'hFFF, 12'h000, 12'h000, 12'h000,
               12'h7FF, 12'h3FF);

    for (int i = 0; i < 3; i++) begin
      s0[0][i] = t0[i].a[0];
      s1[0][i] = t0[i].b[0];
    end
    for (int e = 0; e < 4; e++) begin
      for (int j = 0; j < 4; j++) begin
        s0[1][e*4+j] = t1[e].a[j];
        s1[1][e*4+j] = t1[e].b[j];
      end
    end
    n0[0] = 3;
    n1[0] = 3;
    n0[1] = 16;
    n1[1] = 16;
    d0[0] = 12'h0;
    d1[0] = 12'h0;
    d0[1] = 12'h0;
    d1[1] = 12'h0;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_cs_n", 32'(cs_n[g]), 32'd1);
      check("rst_sck", 32'(sck[g]), 32'd0);
      check("rst_mosi", 32'(mosi[g]), 32'd0);
      check("rst_valid", 32'(valid[g]), 32'd0);
      check("rst_p1", 32'(p1[g]), 32'd0);
      check("rst_p2", 32'(p2[g]), 32'd0);
    end

    rst[0] = 1'b0;
    rst[1] = 1'b0;
    t_rel = cyc;

    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 400, "avg0_valid_timeout");
      if (i == 0) check("avg0_first_valid_cyc", 32'(cyc - t_rel), 32'd152);
      check("avg0_p1", 32'(p1[0]), 32'(t0[i].e1));
      check("avg0_p2", 32'(p2[0]), 32'(t0[i].e2));
    end
    @(negedge clk);
    #1;
    check("avg0_valid_count", 32'(vcnt[0]), 32'd3);
    check("avg0_frame_count", 32'(frames[0]), 32'd6);
    check("cmd_frame1", 32'(cmdlog[0][0]), 32'hD);
    check("cmd_frame2", 32'(cmdlog[0][1]), 32'hF);

    for (int i = 0; i < 4; i++) begin
      wait_valid(1, 700, "avg2_valid_timeout");
      if (i == 0) check("avg2_first_valid_cyc", 32'(cyc - t_rel), 32'd608);
      check("avg2_p1", 32'(p1[1]), 32'(t1[i].e1));
      check("avg2_p2", 32'(p2[1]), 32'(t1[i].e2));
    end

    d0[0] = 12'hE11;
    d1[0] = 12'hEEE;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (!cs_n[0] && m_odd[0] && m_bit[0] >= 8 && m_bit[0] < 17) begin
        hit = 1'b1;
        break;
      end
    end
    check("ch1_shift_found", 32'(hit), 32'd1);
    #1;
    rst[0] = 1'b1;
    #1;
    check("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
    check("mid_rst_sck", 32'(sck[0]), 32'd0);
    check("mid_rst_p1", 32'(p1[0]), 32'd0);
    check("mid_rst_p2", 32'(p2[0]), 32'd0);
    check("mid_rst_valid", 32'(valid[0]), 32'd0);
    @(negedge clk);
    d0[0] = 12'h321;
    d1[0] = 12'h654;
    @(negedge clk);
    rst[0] = 1'b0;
    t_rel = cyc;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      k = k + 1;
      if (!cs_n[0]) break;
    end
    check("post_rst_gap", 32'(k), 32'd4);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!cs_n[0] && m_bit[0] >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("post_rst_bit3_seen", 32'(hit), 32'd1);
    check("post_rst_chan", 32'(m_odd[0]), 32'd0);
    wait_valid(0, 400, "post_rst_valid_timeout");
    check("post_rst_valid_cyc", 32'(cyc - t_rel), 32'd152);
    check("post_rst_p1", 32'(p1[0]), 32'h321);
    check("post_rst_p2", 32'(p2[0]), 32'h654);

    check("frame_len_bad0", 32'(len_bad[0]), 32'd0);
    check("frame_len_bad1", 32'(len_bad[1]), 32'd0);
    check("sck_idle_bad0", 32'(idle_bad[0]), 32'd0);
    check("sck_idle_bad1", 32'(idle_bad[1]), 32'd0);
    check("valid_wide0", 32'(dbl[0]), 32'd0);
    check("valid_wide1", 32'(dbl[1]), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
